// File: rtl/spram_byte_reader.sv
// Streams a contiguous SPRAM word region to uart_tx, low byte first, paced.
// Latency: one cycle from RAM grant to word capture; byte strobes at least PACE cycles apart.
// Backpressure: waits on ram_grant in REQ and on tx_ready plus the pace timer in SEND states.
// Optional checksum trailer byte enabled by defining SPRAM_READER_CKSUM_EN.
module spram_byte_reader #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16,
    parameter int PACE   = 524288
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [CNT_W-1:0]  i_byte_count,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_rd_req,
    input  logic              i_ram_grant,
    input  logic [15:0]       i_ram_rdata,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_strobe,
    input  logic              i_tx_ready
);

    // PACE-1 always fits in clog2(PACE) bits for PACE >= 2.
    localparam int PACE_W = $clog2(PACE);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(PACE - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_REQ     = 4'd1,
        S_CAPT    = 4'd2,
        S_SEND_LO = 4'd3,
        S_GAP_LO  = 4'd4,
        S_SEND_HI = 4'd5,
        S_GAP_HI  = 4'd6,
`ifdef SPRAM_READER_CKSUM_EN
        S_SEND_CK = 4'd8,
        S_GAP_CK  = 4'd9,
`endif
        S_FIN     = 4'd7
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_after_data;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_rem;
    logic [15:0]         r_word;
    logic [PACE_W-1:0]   r_pace;
    logic [7:0]          r_tx_data;
    logic                r_tx_strobe;
    logic                w_accept;
    logic                w_pace_expired;
    logic                w_fire;
    logic                w_data_fire;
    logic [7:0]          w_tx_byte;
`ifdef SPRAM_READER_CKSUM_EN
    logic [7:0]          r_sum;
`endif

    assign w_accept       = (r_state == S_IDLE) && i_start;
    assign w_pace_expired = (r_pace == '0);
    assign w_data_fire    = w_fire && ((r_state == S_SEND_LO) || (r_state == S_SEND_HI));

    // Where the stream goes once the last data byte has been sent.
`ifdef SPRAM_READER_CKSUM_EN
    assign w_after_data = S_SEND_CK;
`else
    assign w_after_data = S_FIN;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the byte-fire decision.
    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_tx_byte    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_byte_count != '0) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = w_after_data;
                    end
                end
            end
            S_REQ: begin
                if (i_ram_grant) begin
                    w_next_state = S_CAPT;
                end
            end
            S_CAPT: begin
                w_next_state = S_SEND_LO;
            end
            S_SEND_LO: begin
                w_tx_byte = r_word[7:0];
                if (i_tx_ready && w_pace_expired) begin
                    w_fire       = 1'b1;
                    w_next_state = S_GAP_LO;
                end
            end
            S_GAP_LO: begin
                // Dead cycle: tx_ready may still read high right after a strobe.
                if (r_rem == '0) begin
                    w_next_state = w_after_data;
                end else begin
                    w_next_state = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                w_tx_byte = r_word[15:8];
                if (i_tx_ready && w_pace_expired) begin
                    w_fire       = 1'b1;
                    w_next_state = S_GAP_HI;
                end
            end
            S_GAP_HI: begin
                if (r_rem == '0) begin
                    w_next_state = w_after_data;
                end else begin
                    w_next_state = S_REQ;
                end
            end
`ifdef SPRAM_READER_CKSUM_EN
            S_SEND_CK: begin
                w_tx_byte = r_sum;
                if (i_tx_ready && w_pace_expired) begin
                    w_fire       = 1'b1;
                    w_next_state = S_GAP_CK;
                end
            end
            S_GAP_CK: begin
                w_next_state = S_FIN;
            end
`endif
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Address and remaining-count tracking; address wraps naturally at ADDR_W bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_addr <= i_start_addr;
            r_rem  <= i_byte_count;
        end else begin
            if (w_data_fire) begin
                r_rem <= r_rem - 1'b1;
            end
            if ((r_state == S_GAP_HI) && (r_rem != '0)) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Word holding register: RAM data is valid exactly one cycle after the grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
        end else if (r_state == S_CAPT) begin
            r_word <= i_ram_rdata;
        end
    end

    // Pace timer: reloads on every strobe, counts down and sticks at zero (expired).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pace <= '0;
        end else if (w_fire) begin
            r_pace <= PACE_RELOAD;
        end else if (!w_pace_expired) begin
            r_pace <= r_pace - 1'b1;
        end
    end

    // Registered tx interface: strobe lasts one cycle, data holds the last byte sent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_strobe <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_tx_strobe <= w_fire;
            if (w_fire) begin
                r_tx_data <= w_tx_byte;
            end
        end
    end

`ifdef SPRAM_READER_CKSUM_EN
    // Running mod-256 sum of the data bytes of the current transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= 8'h00;
        end else if (w_accept) begin
            r_sum <= 8'h00;
        end else if (w_data_fire) begin
            r_sum <= r_sum + w_tx_byte;
        end
    end
`endif

    assign o_busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done       = (r_state == S_FIN);
    assign o_ram_rd_req = (r_state == S_REQ);
    assign o_ram_addr   = r_addr;
    assign o_tx_data    = r_tx_data;
    assign o_tx_strobe  = r_tx_strobe;

endmodule
